cpu6_pipereg_hs: RTL

Parametrised, handshaked pipeline-stage register for cpu6. It generalises the fixed EX/MEM latch: an arbitrary-width payload, a valid/ready handshake in both directions instead of free-running capture, a flush that clears the stage, and a saturating stall-cycle counter. It is instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and is built on the same flop style as the existing pipeline registers.

---
 rtl/cpu6_pipereg_hs.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cpu6_pipereg_hs.sv
// cpu6_pipereg_hs
// Handshaked pipeline-stage register for cpu6. It sits between two pipeline
// stages and moves one payload per cycle under valid/ready flow control. It also
// supports a synchronous flush and keeps a saturating count of stalled cycles.
//
// Build option:
//   CPU6_PIPEREG_SKID_EN  When defined, adds a second (skid) entry. in_ready then
//                         comes straight from a flop, so there is no combinational
//                         path from out_ready to in_ready. Capacity becomes 2.
//                         When undefined, the stage has a single entry, capacity 1,
//                         and in_ready = ~out_valid | out_ready.
//
// Parameters:
//   WIDTH          payload width in bits
//   CLEAR_PAYLOAD  1: flush and drain-to-empty zero the payload registers
//                  0: payload registers keep their value; only valid clears
//   CNT_W          stall counter width
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset; clears all state
//   flush      synchronous stage kill; highest priority; blocks any accept
//   in_valid   upstream payload valid
//   in_data    upstream payload
//   in_ready   stage can accept this cycle
//   out_valid  downstream payload valid
//   out_data   downstream payload
//   out_ready  downstream accepts this cycle
//   cnt_clr    synchronous clear of the stall counter (beats increment)
//   stall_cnt  saturating count of cycles with out_valid & ~out_ready

module cpu6_pipereg_hs #(
  parameter int WIDTH         = 32,
  parameter int CLEAR_PAYLOAD = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam bit ClearPay = (CLEAR_PAYLOAD != 0);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             mainValid;
  logic [WIDTH-1:0] mainData;
  logic [CNT_W-1:0] stallCnt;
  logic             accept;
  logic             drain;

  assign out_valid = mainValid;
  assign out_data  = mainData;
  assign stall_cnt = stallCnt;

  // flush suppresses acceptance even when in_ready is high, so a word
  // presented in the flush cycle is never captured.
  assign accept = in_valid & in_ready & ~flush;
  assign drain  = mainValid & out_ready;

`ifdef CPU6_PIPEREG_SKID_EN

  logic             skidValid;
  logic [WIDTH-1:0] skidData;

  // The skid entry is only ever filled while the main entry is full. Its
  // valid flag therefore tells us when both entries are in use.
  assign in_ready = ~skidValid;

  // Two-entry FIFO. The head is in the main register and the second word is
  // in skid. When skid is full, in_ready is low, so accept and a full skid
  // never happen together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mainValid <= 1'b0;
      mainData  <= '0;
      skidValid <= 1'b0;
      skidData  <= '0;
    end else if (flush) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      if (ClearPay) begin
        mainData <= '0;
        skidData <= '0;
      end
    end else if (skidValid) begin
      if (drain) begin
        mainData  <= skidData;
        skidValid <= 1'b0;
        if (ClearPay) begin
          skidData <= '0;
        end
      end
    end else if (accept) begin
      if (mainValid && !drain) begin
        skidData  <= in_data;
        skidValid <= 1'b1;
      end else begin
        mainData  <= in_data;
        mainValid <= 1'b1;
      end
    end else if (drain) begin
      mainValid <= 1'b0;
      if (ClearPay) begin
        mainData <= '0;
      end
    end
  end

`else

  // Single entry. If the stage is draining this cycle, it can take a new word
  // in the same cycle. This is what gives full throughput without a bubble.
  assign in_ready = ~mainValid | out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mainValid <= 1'b0;
      mainData  <= '0;
    end else if (flush) begin
      mainValid <= 1'b0;
      if (ClearPay) begin
        mainData <= '0;
      end
    end else if (accept) begin
      mainData  <= in_data;
      mainValid <= 1'b1;
    end else if (drain) begin
      mainValid <= 1'b0;
      if (ClearPay) begin
        mainData <= '0;
      end
    end
  end

`endif

  // The counter keeps running through a flush, because flush and cnt_clr are
  // independent controls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt <= '0;
    end else if (cnt_clr) begin
      stallCnt <= '0;
    end else if (mainValid && !out_ready && (stallCnt != CntMax)) begin
      stallCnt <= stallCnt + CntOne;
    end
  end

endmodule
